reorder_buffer: RTL and testbench

//  In-order retirement buffer between decoder/issue and the register file of the Tomasulo core.

---
 rtl/reorder_buffer_pkg.sv | 43 ++++
 rtl/reorder_buffer_operand_lookup.sv | 52 +++++
 rtl/reorder_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants, types and tag helpers for the reorder buffer.
// Tags are ROB_ID_WIDTH+1 bits wide: tag = entry index + 1, tag 0 means "no producer".
package reorder_buffer_pkg;

   localparam int ROB_SIZE     = 8;
   localparam int ROB_ID_WIDTH = 3;
   localparam int VAL_WIDTH    = 32;
   localparam int REG_WIDTH    = 5;

   typedef logic [ROB_ID_WIDTH-1:0] rob_idx_t;
   typedef logic [ROB_ID_WIDTH:0]   rob_tag_t;
   typedef logic [VAL_WIDTH-1:0]    rob_val_t;
   typedef logic [REG_WIDTH-1:0]    rob_reg_t;

   // Label value meaning "operand already lives in the register file"
   localparam rob_tag_t TAG_NONE = '0;
   // Highest legal tag, also the occupancy count of a full buffer
   localparam rob_tag_t TAG_MAX  = rob_tag_t'(ROB_SIZE);

   typedef struct packed {
      logic     valid;
      logic     ready;
      logic     is_br;
      logic     pred_taken;
      logic     taken;
      rob_reg_t rd;
      rob_val_t value;
      rob_val_t alt_pc;
   } rob_entry_t;

   function automatic rob_idx_t tag_to_idx(input rob_tag_t tag);
      return rob_idx_t'(tag - rob_tag_t'(1));
   endfunction

   function automatic rob_tag_t idx_to_tag(input rob_idx_t idx);
      return rob_tag_t'({1'b0, idx}) + rob_tag_t'(1);
   endfunction

   function automatic logic tag_in_range(input rob_tag_t tag);
      return (tag != TAG_NONE) && (tag <= TAG_MAX);
   endfunction

endpackage

// File: rtl/reorder_buffer_operand_lookup.sv
// Combinational label -> value resolver for one source operand.
// Optional macro ROB_CDB_BYPASS_EN: a result broadcast on the CDB in the same
// cycle also resolves the operand; without it the consumer snoops the CDB later.
module reorder_buffer_operand_lookup
   import reorder_buffer_pkg::*;
(
   input  logic [ROB_ID_WIDTH:0]               lab_i,
   input  logic [VAL_WIDTH-1:0]                rf_val_i,
   input  logic [ROB_SIZE-1:0]                 ent_ready_i,
   input  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]  ent_val_i,
   input  logic                                cdb_en_i,
   input  logic [ROB_ID_WIDTH:0]               cdb_tag_i,
   input  logic [VAL_WIDTH-1:0]                cdb_val_i,
   output logic                                rdy_o,
   output logic [VAL_WIDTH-1:0]                val_o,
   output logic [ROB_ID_WIDTH:0]               tag_o
);

   rob_idx_t idx;
   assign idx = tag_to_idx(lab_i);

   // Resolve the label: RF value, same-cycle CDB (optional), finished ROB entry, else wait on tag
   always_comb begin
      rdy_o = 1'b0;
      val_o = '0;
      tag_o = lab_i;
      if (lab_i == TAG_NONE) begin
         rdy_o = 1'b1;
         val_o = rf_val_i;
         tag_o = TAG_NONE;
      end
`ifdef ROB_CDB_BYPASS_EN
      else if (cdb_en_i && (cdb_tag_i == lab_i)) begin
         rdy_o = 1'b1;
         val_o = cdb_val_i;
         tag_o = TAG_NONE;
      end
`endif
      else if (ent_ready_i[idx]) begin
         rdy_o = 1'b1;
         val_o = ent_val_i[idx];
         tag_o = TAG_NONE;
      end
   end

`ifndef ROB_CDB_BYPASS_EN
   // CDB inputs only matter when the bypass is built in
   logic unused_cdb;
   assign unused_cdb = ^{cdb_en_i, cdb_tag_i, cdb_val_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates rename tags at issue, captures CDB results,
// retires the head entry in order (one per cycle) and flushes on a
// mispredicted branch at the head. Optional macro ROB_CDB_BYPASS_EN enables
// same-cycle CDB forwarding in the operand lookups.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_in_n,
   input  logic                    rdy_in,
   // issue side
   input  logic                    dec2rob_en,
   input  logic [REG_WIDTH-1:0]    dec_rd,
   input  logic                    dec_is_br,
   input  logic                    dec_pred_taken,
   input  logic [VAL_WIDTH-1:0]    dec_alt_pc,
   output logic                    rob_full,
   output logic [ROB_ID_WIDTH:0]   rob2rf_tag,
   // operand lookup
   input  logic [ROB_ID_WIDTH:0]   rf2rob_lab1,
   input  logic [ROB_ID_WIDTH:0]   rf2rob_lab2,
   input  logic [VAL_WIDTH-1:0]    rf2rob_val1,
   input  logic [VAL_WIDTH-1:0]    rf2rob_val2,
   output logic                    rob_src1_rdy,
   output logic [VAL_WIDTH-1:0]    rob_src1_val,
   output logic [ROB_ID_WIDTH:0]   rob_src1_tag,
   output logic                    rob_src2_rdy,
   output logic [VAL_WIDTH-1:0]    rob_src2_val,
   output logic [ROB_ID_WIDTH:0]   rob_src2_tag,
   // result bus
   input  logic                    cdb_en,
   input  logic [ROB_ID_WIDTH:0]   cdb_tag,
   input  logic [VAL_WIDTH-1:0]    cdb_val,
   input  logic                    cdb_taken,
   // commit / flush
   output logic                    commit_en,
   output logic [REG_WIDTH-1:0]    rob2rf_commit_rd,
   output logic [VAL_WIDTH-1:0]    rob2rf_commit_res,
   output logic [ROB_ID_WIDTH:0]   rob2rf_commit_lab,
   output logic                    flush,
   output logic [VAL_WIDTH-1:0]    flush_pc
);

   rob_entry_t entry_q [ROB_SIZE];

   rob_idx_t   head_q, head_d;
   rob_idx_t   tail_q, tail_d;
   rob_tag_t   count_q, count_d;

   logic       commit_en_q, commit_en_d;
   rob_reg_t   commit_rd_q, commit_rd_d;
   rob_val_t   commit_res_q, commit_res_d;
   rob_tag_t   commit_lab_q, commit_lab_d;
   logic       flush_q, flush_d;
   rob_val_t   flush_pc_q, flush_pc_d;

   rob_entry_t head_ent;
   logic       head_done;
   logic       mispredict;
   logic       commit_fire;
   logic       issue_fire;
   logic       cdb_hit;
   rob_idx_t   cdb_idx;

   logic [ROB_SIZE-1:0]                ent_ready;
   logic [ROB_SIZE-1:0][VAL_WIDTH-1:0] ent_val;

   // Occupancy comes from the registered count, so a commit in the same
   // cycle never opens a slot for an issue into a full buffer.
   assign rob_full   = (count_q == TAG_MAX);
   assign rob2rf_tag = idx_to_tag(tail_q);

   assign head_ent    = entry_q[head_q];
   assign head_done   = head_ent.valid & head_ent.ready;
   assign mispredict  = head_done & head_ent.is_br & (head_ent.taken != head_ent.pred_taken);
   assign commit_fire = head_done & ~mispredict;
   // A flush (being raised or still visible) discards any issue request
   assign issue_fire  = dec2rob_en & ~rob_full & ~flush_q & ~mispredict;

   assign cdb_idx = tag_to_idx(cdb_tag);
   assign cdb_hit = cdb_en & tag_in_range(cdb_tag) & entry_q[cdb_idx].valid;

   // Flatten per-entry ready/value for the lookup units
   for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_flat
      assign ent_ready[gi] = entry_q[gi].ready;
      assign ent_val[gi]   = entry_q[gi].value;
   end

   // Next-state for pointers, occupancy and the registered commit/flush outputs
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      commit_en_d  = 1'b0;
      commit_rd_d  = '0;
      commit_res_d = '0;
      commit_lab_d = '0;
      flush_d      = 1'b0;
      flush_pc_d   = '0;
      if (mispredict) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         flush_d    = 1'b1;
         flush_pc_d = head_ent.alt_pc;
      end else begin
         if (issue_fire) begin
            tail_d = tail_q + rob_idx_t'(1);
         end
         if (commit_fire) begin
            head_d       = head_q + rob_idx_t'(1);
            commit_en_d  = 1'b1;
            // branches write no register
            commit_rd_d  = head_ent.is_br ? '0 : head_ent.rd;
            commit_res_d = head_ent.value;
            commit_lab_d = idx_to_tag(head_q);
         end
         case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + rob_tag_t'(1);
            2'b01:   count_d = count_q - rob_tag_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and output registers; everything holds while rdy_in is low
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         commit_en_q  <= 1'b0;
         commit_rd_q  <= '0;
         commit_res_q <= '0;
         commit_lab_q <= '0;
         flush_q      <= 1'b0;
         flush_pc_q   <= '0;
      end else if (rdy_in) begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         commit_en_q  <= commit_en_d;
         commit_rd_q  <= commit_rd_d;
         commit_res_q <= commit_res_d;
         commit_lab_q <= commit_lab_d;
         flush_q      <= flush_d;
         flush_pc_q   <= flush_pc_d;
      end
   end

   // Entry storage: allocate at tail, fill from CDB, retire at head, clear on flush.
   // The ready bit is kept after retirement so a consumer whose RF label still
   // names the tag during the commit-to-RF cycle continues to resolve it.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entry_q[i] <= '0;
         end
      end else if (rdy_in) begin
         if (mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
               entry_q[i].valid <= 1'b0;
               entry_q[i].ready <= 1'b0;
            end
         end else begin
            if (issue_fire) begin
               entry_q[tail_q] <= '{valid: 1'b1, ready: 1'b0, is_br: dec_is_br,
                                    pred_taken: dec_pred_taken, taken: 1'b0,
                                    rd: dec_rd, value: '0, alt_pc: dec_alt_pc};
            end
            if (cdb_hit) begin
               entry_q[cdb_idx].ready <= 1'b1;
               entry_q[cdb_idx].value <= cdb_val;
               entry_q[cdb_idx].taken <= cdb_taken;
            end
            if (commit_fire) begin
               entry_q[head_q].valid <= 1'b0;
            end
         end
      end
   end

   // Commit and flush strobes are suppressed while the core is stalled
   assign commit_en         = commit_en_q & rdy_in;
   assign rob2rf_commit_rd  = commit_rd_q;
   assign rob2rf_commit_res = commit_res_q;
   assign rob2rf_commit_lab = commit_lab_q;
   assign flush             = flush_q & rdy_in;
   assign flush_pc          = flush_pc_q;

   reorder_buffer_operand_lookup u_lookup_rs1 (
      .lab_i       (rf2rob_lab1),
      .rf_val_i    (rf2rob_val1),
      .ent_ready_i (ent_ready),
      .ent_val_i   (ent_val),
      .cdb_en_i    (cdb_en),
      .cdb_tag_i   (cdb_tag),
      .cdb_val_i   (cdb_val),
      .rdy_o       (rob_src1_rdy),
      .val_o       (rob_src1_val),
      .tag_o       (rob_src1_tag)
   );

   reorder_buffer_operand_lookup u_lookup_rs2 (
      .lab_i       (rf2rob_lab2),
      .rf_val_i    (rf2rob_val2),
      .ent_ready_i (ent_ready),
      .ent_val_i   (ent_val),
      .cdb_en_i    (cdb_en),
      .cdb_tag_i   (cdb_tag),
      .cdb_val_i   (cdb_val),
      .rdy_o       (rob_src2_rdy),
      .val_o       (rob_src2_val),
      .tag_o       (rob_src2_tag)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: expected commits are queued at issue
// and compared when commit_en appears; directed checks cover full, lookup,
// bypass (ROB_CDB_BYPASS_EN), mispredict flush, stall and async reset.
module tb_reorder_buffer;

   logic        clk;
   logic        rst_in_n;
   logic        rdy_in;
   logic        dec2rob_en;
   logic [4:0]  dec_rd;
   logic        dec_is_br;
   logic        dec_pred_taken;
   logic [31:0] dec_alt_pc;
   logic        rob_full;
   logic [3:0]  rob2rf_tag;
   logic [3:0]  rf2rob_lab1, rf2rob_lab2;
   logic [31:0] rf2rob_val1, rf2rob_val2;
   logic        rob_src1_rdy, rob_src2_rdy;
   logic [31:0] rob_src1_val, rob_src2_val;
   logic [3:0]  rob_src1_tag, rob_src2_tag;
   logic        cdb_en;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        cdb_taken;
   logic        commit_en;
   logic [4:0]  rob2rf_commit_rd;
   logic [31:0] rob2rf_commit_res;
   logic [3:0]  rob2rf_commit_lab;
   logic        flush;
   logic [31:0] flush_pc;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] res;
      logic [3:0]  lab;
   } sb_t;

   sb_t exp_q[$];
   sb_t mon_e;
   int  total;
   int  bad;
   int  flush_cnt;
   int  ntag;
   int  plan_val [9];
   int  drain_order [7] = '{8, 4, 1, 3, 6, 5, 7};

   reorder_buffer dut (
      .clk               (clk),
      .rst_in_n          (rst_in_n),
      .rdy_in            (rdy_in),
      .dec2rob_en        (dec2rob_en),
      .dec_rd            (dec_rd),
      .dec_is_br         (dec_is_br),
      .dec_pred_taken    (dec_pred_taken),
      .dec_alt_pc        (dec_alt_pc),
      .rob_full          (rob_full),
      .rob2rf_tag        (rob2rf_tag),
      .rf2rob_lab1       (rf2rob_lab1),
      .rf2rob_lab2       (rf2rob_lab2),
      .rf2rob_val1       (rf2rob_val1),
      .rf2rob_val2       (rf2rob_val2),
      .rob_src1_rdy      (rob_src1_rdy),
      .rob_src1_val      (rob_src1_val),
      .rob_src1_tag      (rob_src1_tag),
      .rob_src2_rdy      (rob_src2_rdy),
      .rob_src2_val      (rob_src2_val),
      .rob_src2_tag      (rob_src2_tag),
      .cdb_en            (cdb_en),
      .cdb_tag           (cdb_tag),
      .cdb_val           (cdb_val),
      .cdb_taken         (cdb_taken),
      .commit_en         (commit_en),
      .rob2rf_commit_rd  (rob2rf_commit_rd),
      .rob2rf_commit_res (rob2rf_commit_res),
      .rob2rf_commit_lab (rob2rf_commit_lab),
      .flush             (flush),
      .flush_pc          (flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      dec2rob_en     = 1'b0;
      dec_rd         = '0;
      dec_is_br      = 1'b0;
      dec_pred_taken = 1'b0;
      dec_alt_pc     = '0;
      cdb_en         = 1'b0;
      cdb_tag        = '0;
      cdb_val        = '0;
      cdb_taken      = 1'b0;
   endtask

   task automatic do_issue(input int rd, input int is_br, input int pred, input int alt);
      dec2rob_en     = 1'b1;
      dec_rd         = 5'(rd);
      dec_is_br      = 1'(is_br);
      dec_pred_taken = 1'(pred);
      dec_alt_pc     = 32'(alt);
   endtask

   task automatic do_cdb(input int tag, input int val, input int taken);
      cdb_en    = 1'b1;
      cdb_tag   = 4'(tag);
      cdb_val   = 32'(val);
      cdb_taken = 1'(taken);
   endtask

   task automatic push_exp(input int rd, input int res, input int lab);
      exp_q.push_back('{rd: 5'(rd), res: 32'(res), lab: 4'(lab)});
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      step();
   endtask

   // Commit monitor: every commit must match the oldest expected retirement
   always @(negedge clk) begin
      if (rst_in_n === 1'b1) begin
         if (flush === 1'b1) flush_cnt++;
         if (commit_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("commit_extra", 32'(commit_en), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               $display("commit lab=%0d rd=%0d res=0x%0h", rob2rf_commit_lab, rob2rf_commit_rd, rob2rf_commit_res);
               chk("commit_rd", 32'(rob2rf_commit_rd), 32'(mon_e.rd));
               chk("commit_res", rob2rf_commit_res, mon_e.res);
               chk("commit_lab", 32'(rob2rf_commit_lab), 32'(mon_e.lab));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; flush_cnt = 0;
      rst_in_n = 1'b0; rdy_in = 1'b1;
      clr_in();
      rf2rob_lab1 = '0; rf2rob_lab2 = '0; rf2rob_val1 = '0; rf2rob_val2 = '0;
      #12;
      // reset state
      chk("rst_commit_en", 32'(commit_en), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_full", 32'(rob_full), 32'd0);
      chk("rst_tag", 32'(rob2rf_tag), 32'd1);
      chk("rst_commit_rd", 32'(rob2rf_commit_rd), 32'd0);
      chk("rst_commit_res", rob2rf_commit_res, 32'd0);
      chk("rst_commit_lab", 32'(rob2rf_commit_lab), 32'd0);
      chk("rst_flush_pc", flush_pc, 32'd0);
      @(negedge clk);
      rst_in_n = 1'b1;
      step();

      // basic issue -> CDB -> commit latency
      do_issue(5, 0, 0, 0);
      push_exp(5, 'h2A, 1);
      @(negedge clk);
      chk("t1_tag", 32'(rob2rf_tag), 32'd1);
      step(); clr_in();
      do_cdb(1, 'h2A, 0);
      @(negedge clk);
      chk("t1_no_commit_cdb", 32'(commit_en), 32'd0);
      step(); clr_in();
      @(negedge clk);
      chk("t1_lat0", 32'(commit_en), 32'd0);
      step();
      @(negedge clk);
      chk("t1_lat1", 32'(commit_en), 32'd1);
      step();

      // fill to full, tags wrap 2..8,1
      ntag = 2;
      for (int i = 0; i < 8; i++) begin
         plan_val[ntag] = 'hA000 + i * 'h13;
         do_issue(i + 1, 0, 0, 0);
         push_exp(i + 1, plan_val[ntag], ntag);
         @(negedge clk);
         chk("fill_tag", 32'(rob2rf_tag), 32'(ntag));
         chk("fill_not_full", 32'(rob_full), 32'd0);
         step();
         ntag = (ntag == 8) ? 1 : ntag + 1;
      end
      clr_in();
      @(negedge clk);
      chk("full_set", 32'(rob_full), 32'd1);
      chk("full_tag", 32'(rob2rf_tag), 32'd2);
      do_issue(20, 0, 0, 0);
      step(); clr_in();
      @(negedge clk);
      chk("ninth_refused", 32'(rob2rf_tag), 32'd2);
      do_cdb(2, plan_val[2], 0);
      step(); clr_in();
      do_issue(21, 0, 0, 0);
      @(negedge clk);
      chk("full_commit_cycle", 32'(rob_full), 32'd1);
      step(); clr_in();
      @(negedge clk);
      chk("full_clears", 32'(rob_full), 32'd0);
      chk("same_cycle_issue_refused", 32'(rob2rf_tag), 32'd2);
      step();
      // out-of-order completion, in-order retirement
      for (int i = 0; i < 7; i++) begin
         do_cdb(drain_order[i], plan_val[drain_order[i]], 0);
         step(); clr_in();
      end
      wait_drain(40);

      // operand lookup: tags 2 and 3
      do_issue(1, 0, 0, 0);
      push_exp(1, 'h55, 2);
      step();
      do_issue(2, 0, 0, 0);
      push_exp(2, 7, 3);
      step(); clr_in();
      rf2rob_lab1 = 4'd3;
      @(negedge clk);
      chk("lk_nrdy", 32'(rob_src1_rdy), 32'd0);
      chk("lk_nrdy_tag", 32'(rob_src1_tag), 32'd3);
      do_cdb(3, 7, 0);
      step(); clr_in();
      @(negedge clk);
      chk("lk_rdy", 32'(rob_src1_rdy), 32'd1);
      chk("lk_val", rob_src1_val, 32'd7);
      chk("lk_rdy_tag", 32'(rob_src1_tag), 32'd0);
      rf2rob_lab1 = 4'd0; rf2rob_val1 = 32'd9;
      #1;
      chk("lk_rf_rdy", 32'(rob_src1_rdy), 32'd1);
      chk("lk_rf_val", rob_src1_val, 32'd9);
      rf2rob_lab2 = 4'd2;
      do_cdb(2, 'h55, 0);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("byp_rdy", 32'(rob_src2_rdy), 32'd1);
      chk("byp_val", rob_src2_val, 32'h55);
`else
      chk("byp_rdy", 32'(rob_src2_rdy), 32'd0);
      chk("byp_tag", 32'(rob_src2_tag), 32'd2);
`endif
      step(); clr_in();
      @(negedge clk);
      chk("lk_after_cdb_rdy", 32'(rob_src2_rdy), 32'd1);
      chk("lk_after_cdb_val", rob_src2_val, 32'h55);
      rf2rob_lab2 = 4'd0; rf2rob_val1 = '0;
      step();
      wait_drain(20);

      // mispredicted branch at head (tag 4) with a younger entry (tag 5)
      do_issue(10, 1, 0, 'h100);
      step();
      do_issue(7, 0, 0, 0);
      step(); clr_in();
      do_cdb(5, 'h11, 0);
      step(); clr_in();
      do_cdb(4, 0, 1);
      step(); clr_in();
      do_issue(12, 0, 0, 0);
      @(negedge clk);
      chk("mp_not_yet", 32'(flush), 32'd0);
      step(); clr_in();
      @(negedge clk);
      chk("mp_flush", 32'(flush), 32'd1);
      chk("mp_flush_pc", flush_pc, 32'h100);
      chk("mp_no_commit", 32'(commit_en), 32'd0);
      chk("mp_tag_reset", 32'(rob2rf_tag), 32'd1);
      chk("mp_not_full", 32'(rob_full), 32'd0);
      step();
      @(negedge clk);
      chk("mp_one_cycle", 32'(flush), 32'd0);
      step();

      // correctly predicted branch commits with rd=0, no flush
      do_issue(9, 1, 1, 'h200);
      push_exp(0, 'hBEEF, 1);
      step(); clr_in();
      do_cdb(1, 'hBEEF, 1);
      step(); clr_in();
      wait_drain(20);
      chk("flush_count", 32'(flush_cnt), 32'd1);

      // stall: rdy_in low for 3 cycles amid issue and CDB traffic
      do_issue(3, 0, 0, 0);
      push_exp(3, 'h77, 2);
      step(); clr_in();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_issue(14, 0, 0, 0);
         do_cdb(2, 'hDEAD, 0);
         @(negedge clk);
         chk("stall_no_commit", 32'(commit_en), 32'd0);
         chk("stall_tag", 32'(rob2rf_tag), 32'd3);
         step();
      end
      clr_in();
      rdy_in = 1'b1;
      rf2rob_lab1 = 4'd2;
      @(negedge clk);
      chk("stall_held_tag", 32'(rob2rf_tag), 32'd3);
      chk("stall_not_ready", 32'(rob_src1_rdy), 32'd0);
      rf2rob_lab1 = 4'd0;
      step();
      do_cdb(2, 'h77, 0);
      step(); clr_in();
      wait_drain(20);

      // async reset while a commit is on the outputs
      do_issue(4, 0, 0, 0);
      push_exp(4, 'h33, 3);
      step();
      do_issue(6, 0, 0, 0);
      push_exp(6, 'h44, 4);
      step(); clr_in();
      do_cdb(3, 'h33, 0);
      step();
      do_cdb(4, 'h44, 0);
      step(); clr_in();
      chk("pre_rst_commit", 32'(commit_en), 32'd1);
      #2;
      rst_in_n = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_commit_en", 32'(commit_en), 32'd0);
      chk("arst_commit_lab", 32'(rob2rf_commit_lab), 32'd0);
      chk("arst_commit_res", rob2rf_commit_res, 32'd0);
      chk("arst_tag", 32'(rob2rf_tag), 32'd1);
      chk("arst_full", 32'(rob_full), 32'd0);
      step();
      chk("arst_hold", 32'(commit_en), 32'd0);
      @(negedge clk);
      rst_in_n = 1'b1;
      step();

      // recovery after reset
      do_issue(6, 0, 0, 0);
      push_exp(6, 'h66, 1);
      @(negedge clk);
      chk("post_rst_tag", 32'(rob2rf_tag), 32'd1);
      step(); clr_in();
      do_cdb(1, 'h66, 0);
      step(); clr_in();
      wait_drain(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
